// File: rtl/p2s_wide.sv
// p2s_wide: W-bit word to W/L serial beats of L bits, one-word skid buffer.
// Optional trailing even-parity beat when P2S_PARITY_EN is defined.
module p2s_wide #(
    parameter int W = 8,
    parameter int L = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] par_data,
    input  logic         par_valid,
    input  logic         par_msb_first,
    output logic         par_ready,
    output logic [L-1:0] ser_data,
    output logic         ser_valid,
    output logic         ser_last,
    input  logic         ser_ready,
    output logic         busy
);

    localparam int BEATS = W / L;
`ifdef P2S_PARITY_EN
    localparam int NB = BEATS + 1;
`else
    localparam int NB = BEATS;
`endif
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] LASTC = CW'(NB - 1);

    generate
        if (W < 2 || L < 1 || (W % L) != 0) begin : g_bad_cfg
            $error("p2s_wide: W must be >= 2 and a multiple of L");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_shift;
    logic [W-1:0]  r_skid;
    logic [CW-1:0] r_cnt;
    logic          r_msb;
    logic          r_skid_msb;
    logic          r_skid_full;

    logic [W-1:0]  w_ld_data;
    logic          w_ld_msb;
    logic          w_in_acc;
    logic          w_beat;
    logic          w_slot;
    logic          w_load;
    logic          w_bypass;

    assign par_ready = !r_skid_full;
    assign w_in_acc  = par_valid && par_ready;
    assign ser_valid = (r_state == SHIFT);
    assign ser_last  = ser_valid && (r_cnt == LASTC);
    assign busy      = ser_valid || r_skid_full;
    assign w_beat    = ser_valid && ser_ready;

    // Shift stage frees up when idle or when its final beat leaves this cycle.
    assign w_slot    = (r_state == IDLE) || (w_beat && ser_last);
    assign w_load    = w_slot && (r_skid_full || w_in_acc);
    assign w_bypass  = w_load && !r_skid_full;
    assign w_ld_data = r_skid_full ? r_skid     : par_data;
    assign w_ld_msb  = r_skid_full ? r_skid_msb : par_msb_first;

`ifdef P2S_PARITY_EN
    logic r_par;

    assign ser_data = (r_cnt == CW'(BEATS)) ? L'(r_par) :
                      r_msb ? r_shift[W-1 -: L] : r_shift[L-1:0];

    // Parity of the word captured as it enters the shift stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^w_ld_data;
        end
    end
`else
    assign ser_data = r_msb ? r_shift[W-1 -: L] : r_shift[L-1:0];
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter SHIFT on any load, drop to IDLE when nothing follows.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_nxt = SHIFT;
            SHIFT:   if (w_beat && ser_last && !w_load) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift register, order bit and beat counter; all hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_msb   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= w_ld_data;
            r_msb   <= w_ld_msb;
            r_cnt   <= '0;
        end else if (w_beat) begin
            r_shift <= r_msb ? (r_shift << L) : (r_shift >> L);
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Skid buffer catches a word only when it cannot go straight to shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid      <= '0;
            r_skid_msb  <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_in_acc && !w_bypass) begin
            r_skid      <= par_data;
            r_skid_msb  <= par_msb_first;
            r_skid_full <= 1'b1;
        end else if (w_load && r_skid_full) begin
            r_skid_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_p2s_wide.sv
// tb_p2s_wide: three p2s_wide configs (8/1, 16/4, 8/2) behind one driver.
// Table-driven words plus streaming, backpressure and reset sequences.
module tb_p2s_wide;

`ifdef P2S_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] d;
    logic        v;
    logic        m;
    logic        sr;
    logic [1:0]  sel;

    logic       a_pr, a_sv, a_sl, a_bz;
    logic [0:0] a_sd;
    logic       b_pr, b_sv, b_sl, b_bz;
    logic [3:0] b_sd;
    logic       c_pr, c_sv, c_sl, c_bz;
    logic [1:0] c_sd;

    logic       o_pr, o_sv, o_sl, o_bz;
    logic [3:0] o_sd;

    int n_tests;
    int n_fail;

    p2s_wide #(.W(8), .L(1)) u_a (
        .clk(clk), .rst(rst),
        .par_data(d[7:0]), .par_valid(v && sel == 2'd0),
        .par_msb_first(m), .par_ready(a_pr),
        .ser_data(a_sd), .ser_valid(a_sv), .ser_last(a_sl),
        .ser_ready(sel == 2'd0 ? sr : 1'b1), .busy(a_bz)
    );

    p2s_wide #(.W(16), .L(4)) u_b (
        .clk(clk), .rst(rst),
        .par_data(d), .par_valid(v && sel == 2'd1),
        .par_msb_first(m), .par_ready(b_pr),
        .ser_data(b_sd), .ser_valid(b_sv), .ser_last(b_sl),
        .ser_ready(sel == 2'd1 ? sr : 1'b1), .busy(b_bz)
    );

    p2s_wide #(.W(8), .L(2)) u_c (
        .clk(clk), .rst(rst),
        .par_data(d[7:0]), .par_valid(v && sel == 2'd2),
        .par_msb_first(m), .par_ready(c_pr),
        .ser_data(c_sd), .ser_valid(c_sv), .ser_last(c_sl),
        .ser_ready(sel == 2'd2 ? sr : 1'b1), .busy(c_bz)
    );

    always_comb begin
        o_pr = a_pr; o_sv = a_sv; o_sl = a_sl; o_bz = a_bz;
        o_sd = {3'b000, a_sd};
        case (sel)
            2'd1: begin
                o_pr = b_pr; o_sv = b_sv; o_sl = b_sl; o_bz = b_bz;
                o_sd = b_sd;
            end
            2'd2: begin
                o_pr = c_pr; o_sv = c_sv; o_sl = c_sl; o_bz = c_bz;
                o_sd = {2'b00, c_sd};
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Send one word with ser_ready high and check every beat in order.
    task automatic run_word(input string nm, input logic [1:0] s,
                            input logic [15:0] w, input logic msb,
                            input logic [63:0] e, input logic p);
        int nb;
        logic [3:0] want;
        nb = (s == 2'd0 ? 8 : 4) + PAR;
        @(negedge clk);
        sel = s; d = w; m = msb; v = 1'b1; sr = 1'b1;
        #1;
        chk({nm, " par_ready"}, 32'(o_pr), 32'd1);
        @(negedge clk);
        v = 1'b0;
        for (int k = 0; k < nb; k++) begin
            want = (k < nb - PAR) ? e[4*k +: 4] : {3'b000, p};
            chk($sformatf("%s b%0d valid", nm, k), 32'(o_sv), 32'd1);
            chk($sformatf("%s b%0d data", nm, k), 32'(o_sd), 32'(want));
            chk($sformatf("%s b%0d last", nm, k), 32'(o_sl),
                32'(k == nb - 1));
            @(negedge clk);
        end
        chk({nm, " valid after"}, 32'(o_sv), 32'd0);
        chk({nm, " busy after"}, 32'(o_bz), 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic [1:0]  s;
        logic [15:0] w;
        logic        m;
        logic [63:0] e;
        logic        p;
    } vec_t;

    vec_t tv[10];

    logic [15:0] bw[3];
    logic [15:0] be[3];
    logic [3:0]  eb[$];
    logic [63:0] bpe;
    logic [3:0]  pat;
    logic [3:0]  hd;
    logic        hl;
    logic        hold;
    logic        pend;
    logic        started;
    logic        saw_nr;
    int          idx, got, gap, total, k;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; d = '0; v = 1'b0; m = 1'b0; sr = 1'b1; sel = 2'd0;

        tv[0] = '{"A5 lsb",   2'd0, 16'h00A5, 1'b0, 64'h10100101, 1'b0};
        tv[1] = '{"07 msb",   2'd0, 16'h0007, 1'b1, 64'h11100000, 1'b1};
        tv[2] = '{"07 lsb",   2'd0, 16'h0007, 1'b0, 64'h00000111, 1'b1};
        tv[3] = '{"03 lsb",   2'd0, 16'h0003, 1'b0, 64'h00000011, 1'b0};
        tv[4] = '{"1234 msb", 2'd1, 16'h1234, 1'b1, 64'h4321,     1'b1};
        tv[5] = '{"1234 lsb", 2'd1, 16'h1234, 1'b0, 64'h1234,     1'b1};
        tv[6] = '{"ABCD msb", 2'd1, 16'hABCD, 1'b1, 64'hDCBA,     1'b0};
        tv[7] = '{"00F0 lsb", 2'd1, 16'h00F0, 1'b0, 64'h00F0,     1'b0};
        tv[8] = '{"1B msb",   2'd2, 16'h001B, 1'b1, 64'h3210,     1'b0};
        tv[9] = '{"E4 lsb",   2'd2, 16'h00E4, 1'b0, 64'h3210,     1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("rst%0d par_ready", s), 32'(o_pr), 32'd1);
            chk($sformatf("rst%0d ser_valid", s), 32'(o_sv), 32'd0);
            chk($sformatf("rst%0d ser_last", s), 32'(o_sl), 32'd0);
            chk($sformatf("rst%0d busy", s), 32'(o_bz), 32'd0);
            chk($sformatf("rst%0d ser_data", s), 32'(o_sd), 32'd0);
        end

        for (int i = 0; i < 10; i++)
            run_word(tv[i].nm, tv[i].s, tv[i].w, tv[i].m, tv[i].e, tv[i].p);

        // Three back-to-back words on the 8/2 instance.
        bw[0] = 16'h1B; bw[1] = 16'hE4; bw[2] = 16'hFF;
        be[0] = 16'h0123; be[1] = 16'h3210; be[2] = 16'h3333;
        eb.delete();
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) eb.push_back(be[w][4*b +: 4]);
            if (PAR == 1) eb.push_back(4'h0);
        end
        total = eb.size();
        @(negedge clk);
        sel = 2'd2; sr = 1'b1; m = 1'b0; d = bw[0]; v = 1'b1;
        idx = 0; got = 0; gap = 0; started = 1'b0; saw_nr = 1'b0;
        #1;
        pend = v && o_pr;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (pend) begin
                idx++;
                if (idx < 3) d = bw[idx];
                else v = 1'b0;
            end
            #1;
            if (o_sv) begin
                started = 1'b1;
                if (got < total) begin
                    chk($sformatf("b2b beat%0d data", got), 32'(o_sd),
                        32'(eb[got]));
                    chk($sformatf("b2b beat%0d last", got), 32'(o_sl),
                        32'((got % (4 + PAR)) == 3 + PAR));
                end
                got++;
            end else if (started && got < total) begin
                gap++;
            end
            if (o_bz && !o_pr) saw_nr = 1'b1;
            pend = v && o_pr;
            if (got >= total && !o_sv) break;
        end
        chk("b2b beats", 32'(got), 32'(total));
        chk("b2b gaps", 32'(gap), 32'd0);
        chk("b2b par_ready low", 32'(saw_nr), 32'd1);
        chk("b2b words taken", 32'(idx), 32'd3);

        // Backpressure on the 8/1 instance, ready pattern 1,0,0,1.
        bpe = 64'h11000011;
        pat = 4'b1001;
        @(negedge clk);
        sel = 2'd0; d = 16'hC3; m = 1'b0; v = 1'b1; sr = 1'b1;
        @(negedge clk);
        v = 1'b0;
        k = 0; hold = 1'b0; hd = '0; hl = 1'b0;
        for (int c = 0; c < 60 && k < 8 + PAR; c++) begin
            sr = pat[c % 4];
            #1;
            if (hold) begin
                chk($sformatf("bp c%0d hold valid", c), 32'(o_sv), 32'd1);
                chk($sformatf("bp c%0d hold data", c), 32'(o_sd), 32'(hd));
                chk($sformatf("bp c%0d hold last", c), 32'(o_sl), 32'(hl));
            end
            if (o_sv && sr) begin
                chk($sformatf("bp beat%0d data", k), 32'(o_sd),
                    32'(k < 8 ? bpe[4*k +: 4] : 4'h0));
                chk($sformatf("bp beat%0d last", k), 32'(o_sl),
                    32'(k == 7 + PAR));
                k++;
            end
            hold = o_sv && !sr;
            hd = o_sd; hl = o_sl;
            @(negedge clk);
        end
        sr = 1'b1;
        #1;
        chk("bp beats", 32'(k), 32'(8 + PAR));
        chk("bp valid after", 32'(o_sv), 32'd0);

        // Reset mid-word with a second word parked in the skid buffer.
        @(negedge clk);
        sel = 2'd0; sr = 1'b1; m = 1'b0; d = 16'hF0; v = 1'b1;
        @(negedge clk);
        d = 16'h55;
        @(negedge clk);
        v = 1'b0;
        #1;
        chk("rst skid full", 32'(o_pr), 32'd0);
        chk("rst busy before", 32'(o_bz), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst ser_valid", 32'(o_sv), 32'd0);
        chk("midrst par_ready", 32'(o_pr), 32'd1);
        chk("midrst busy", 32'(o_bz), 32'd0);
        chk("midrst ser_data", 32'(o_sd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("postrst c%0d valid", c), 32'(o_sv), 32'd0);
            chk($sformatf("postrst c%0d busy", c), 32'(o_bz), 32'd0);
        end
        run_word("0F after rst", 2'd0, 16'h000F, 1'b0, 64'h00001111, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
